egress_arbiter: RTL

Downstream stage of the routing block. Drains the two class FIFOs (FIFO0, FIFO1) that the router fills, and merges them into one 8-bit egress stream using weighted round-robin arbitration. Raises the priority of a FIFO that reports almost_full, honours egress back-pressure, and reports which channel is being served.

---
 rtl/pcie_switch_pkg.sv | 17 +
 rtl/egress_rr_select.sv | 36 +++
 rtl/egress_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pcie_switch_pkg.sv
// Shared definitions for the routing block egress path:
// FSM state encoding, grant encodings and the default data width.
package pcie_switch_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE0 = 2'd1,
        ST_SERVE1 = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_F0   = 2'b01;
    localparam logic [1:0] GRANT_F1   = 2'b10;

endpackage

// File: rtl/egress_rr_select.sv
// Channel selection for the egress arbiter (combinational).
// Ports: empty0/1, af0/1 (almost-full), last (1=FIFO1 served last)
//        in; sel (0=FIFO0, 1=FIFO1) and sel_valid out.
module egress_rr_select (
    input  logic empty0,
    input  logic empty1,
    input  logic af0,
    input  logic af1,
    input  logic last,
    output logic sel,
    output logic sel_valid
);

    logic c0, c1, u0, u1;

    assign c0 = ~empty0;
    assign c1 = ~empty1;
    assign u0 = c0 & af0;
    assign u1 = c1 & af1;

    always_comb begin
        sel_valid = c0 | c1;
        sel       = 1'b0;
        if (c0 && !c1)
            sel = 1'b0;
        else if (c1 && !c0)
            sel = 1'b1;
        else if (u0 && !u1)
            sel = 1'b0;
        else if (u1 && !u0)
            sel = 1'b1;
        else
            sel = ~last;
    end

endmodule

// File: rtl/egress_arbiter.sv
// Weighted round-robin merge of FIFO0/FIFO1 into one egress stream.
// Ports: clk, reset (async, active-low); fifoK_data/empty/almost_full/
// error in; egress_pause in; pop0/pop1 strobes; data_out/valid_out
// (2 cycles after pop); grant one-hot; sticky arb_error.
// Build option ARB_STATS_EN adds per-channel word counters cnt0/cnt1.
module egress_arbiter
    import pcie_switch_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WEIGHT0 = 4,
    parameter int WEIGHT1 = 4
`ifdef ARB_STATS_EN
   ,parameter int CNT_W   = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] fifo0_data,
    input  logic              fifo0_empty,
    input  logic              fifo0_almost_full,
    input  logic              fifo0_error,
    input  logic [DATA_W-1:0] fifo1_data,
    input  logic              fifo1_empty,
    input  logic              fifo1_almost_full,
    input  logic              fifo1_error,
    input  logic              egress_pause,
    output logic              pop0,
    output logic              pop1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        grant,
    output logic              arb_error
`ifdef ARB_STATS_EN
   ,output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    localparam logic [3:0] W0 = 4'(WEIGHT0);
    localparam logic [3:0] W1 = 4'(WEIGHT1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] burst_q, burst_d;

    logic       serving0, serving1, pop;
    logic       cur_empty, cur_af, oth_af;
    logic [3:0] weight, burst_inc;
    logic       exit_a, exit_b, exit_c, leave;
    logic       sel_last, sel, sel_valid;

    logic       pop_d1, tag_d1;

    assign serving0  = (state_q == ST_SERVE0);
    assign serving1  = (state_q == ST_SERVE1);
    assign pop       = pop0 | pop1;
    assign cur_empty = serving1 ? fifo1_empty : fifo0_empty;
    assign cur_af    = serving1 ? fifo1_almost_full : fifo0_almost_full;
    assign oth_af    = serving1 ? fifo0_almost_full : fifo1_almost_full;
    assign weight    = serving1 ? W1 : W0;
    assign burst_inc = burst_q + 4'(pop);

    // Nothing leaves a grant while paused; burst_inc!=0 means at least
    // one word of this grant has been (or is being) popped.
    assign exit_a = pop && (burst_inc == weight);
    assign exit_b = cur_empty && !egress_pause;
    assign exit_c = oth_af && !cur_af && (burst_inc != 4'd0)
                    && !egress_pause;
    assign leave  = (serving0 | serving1) & (exit_a | exit_b | exit_c);

    // On exit the channel just served becomes the last-served one.
    assign sel_last = (state_q == ST_IDLE) ? last_q : serving1;

    egress_rr_select u_sel (
        .empty0    (fifo0_empty),
        .empty1    (fifo1_empty),
        .af0       (fifo0_almost_full),
        .af1       (fifo1_almost_full),
        .last      (sel_last),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            burst_q <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        burst_d = burst_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!egress_pause && sel_valid) begin
                    state_d = sel ? ST_SERVE1 : ST_SERVE0;
                    burst_d = 4'd0;
                end
            end
            ST_SERVE0, ST_SERVE1: begin
                if (leave) begin
                    last_d  = serving1;
                    burst_d = 4'd0;
                    if (sel_valid)
                        state_d = sel ? ST_SERVE1 : ST_SERVE0;
                    else
                        state_d = ST_IDLE;
                end else begin
                    burst_d = burst_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                burst_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        pop0  = serving0 & ~fifo0_empty & ~egress_pause;
        pop1  = serving1 & ~fifo1_empty & ~egress_pause;
        grant = serving0 ? GRANT_F0 :
                serving1 ? GRANT_F1 : GRANT_NONE;
    end

    // Stage 1 marks that FIFO read data arrives this cycle and from
    // which channel; stage 2 registers it onto the egress port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_d1    <= 1'b0;
            tag_d1    <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            arb_error <= 1'b0;
        end else begin
            pop_d1    <= pop;
            tag_d1    <= pop1;
            valid_out <= pop_d1;
            if (pop_d1)
                data_out <= tag_d1 ? fifo1_data : fifo0_data;
            if (fifo0_error || fifo1_error)
                arb_error <= 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    logic tag_d2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_d2 <= 1'b0;
            cnt0   <= '0;
            cnt1   <= '0;
        end else begin
            tag_d2 <= tag_d1;
            if (valid_out && !tag_d2 && cnt0 != '1)
                cnt0 <= cnt0 + 1'b1;
            if (valid_out && tag_d2 && cnt1 != '1)
                cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule
